// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the valid-beat and ready-beat pipes.
package pipe_pkg;

  localparam int unsigned PIPE_DATA_W = 3;
  localparam int unsigned PIPE_STAGES = 2;
  localparam int unsigned STAGES_MAX  = 8;
  localparam int unsigned OCC_W       = 4;

  function automatic logic [OCC_W-1:0] popcount(input logic [STAGES_MAX-1:0] v);
    logic [OCC_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(STAGES_MAX); i++) begin
      n = n + OCC_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_valid_stage.sv
// One forward register slice: registered valid/data with a combinational ready
// that lets the slice refill whenever it is empty or its beat is leaving.
module pipe_valid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              rdy_next_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] dat_o,
  output logic              rdy_o
);

  logic              vld_q, vld_d;
  logic [DATA_W-1:0] dat_q, dat_d;

  assign rdy_o = !vld_q || rdy_next_i;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (rdy_o) begin
      vld_d = in_valid_i;
      // Empty slots keep stale data; the cleared valid masks it.
      if (in_valid_i) dat_d = in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/pipe_valid_beat.sv
// Forward-registered valid/data pipe of STAGES bubble-collapsing slices.
// Optional statistics (occupancy, beat_cnt, stall_cnt) under `define PIPE_STAT_EN.
module pipe_valid_beat
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned STAGES = PIPE_STAGES,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              valid_up,
  input  logic [DATA_W-1:0] data_up,
  output logic              ready_up,
  output logic              valid_down,
  output logic [DATA_W-1:0] data_down,
  input  logic              ready_down,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [STAGES-1:0] vld;
  logic [DATA_W-1:0] dat [STAGES];
  logic [STAGES:0]   rdy;

  assign rdy[STAGES] = ready_down;

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    logic              in_vld;
    logic [DATA_W-1:0] in_dat;

    if (k == 0) begin : g_head
      assign in_vld = valid_up;
      assign in_dat = data_up;
    end else begin : g_body
      assign in_vld = vld[k-1];
      assign in_dat = dat[k-1];
    end

    pipe_valid_stage #(
      .DATA_W(DATA_W)
    ) u_stage (
      .clk_i     (sys_clk),
      .rst_ni    (sys_rst_n),
      .in_valid_i(in_vld),
      .in_data_i (in_dat),
      .rdy_next_i(rdy[k+1]),
      .vld_o     (vld[k]),
      .dat_o     (dat[k]),
      .rdy_o     (rdy[k])
    );
  end

  assign ready_up   = rdy[0];
  assign valid_down = vld[STAGES-1];
  assign data_down  = dat[STAGES-1];

`ifdef PIPE_STAT_EN
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (valid_down && ready_down)  beat_cnt_d  = beat_cnt_q + CNT_W'(1);
    if (valid_down && !ready_down) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign occupancy = popcount(STAGES_MAX'(vld));
  assign beat_cnt  = beat_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign occupancy = '0;
  assign beat_cnt  = {CNT_W{1'b0}};
  assign stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_valid_beat.sv
// Directed self-checking bench for pipe_valid_beat (STAGES=2, DATA_W=3).
module tb_pipe_valid_beat;

  localparam int unsigned DATA_W = 3;
  localparam int unsigned STAGES = 2;
  localparam int unsigned CNT_W  = 16;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              valid_up = 1'b0;
  logic [DATA_W-1:0] data_up = '0;
  logic              ready_up;
  logic              valid_down;
  logic [DATA_W-1:0] data_down;
  logic              ready_down = 1'b0;
  logic [3:0]        occupancy;
  logic [CNT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]  stall_cnt;

  int tests = 0;
  int fails = 0;

  pipe_valid_beat #(
    .DATA_W(DATA_W),
    .STAGES(STAGES),
    .CNT_W (CNT_W)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .valid_up  (valid_up),
    .data_up   (data_up),
    .ready_up  (ready_up),
    .valid_down(valid_down),
    .data_down (data_down),
    .ready_down(ready_down),
    .occupancy (occupancy),
    .beat_cnt  (beat_cnt),
    .stall_cnt (stall_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; valid_up = 1'b0; ready_down = 1'b0; data_up = '0;
    tick(); tick();
    tests++; if (valid_down !== 1'b0) begin fails++;
      $display("FAIL reset_valid_down: got %b want 0", valid_down); end
    tests++; if (data_down !== 3'd0) begin fails++;
      $display("FAIL reset_data_down: got %0d want 0", data_down); end
    tests++; if (occupancy !== 4'd0 || beat_cnt !== 16'd0 || stall_cnt !== 16'd0) begin fails++;
      $display("FAIL reset_stats: got occ=%0d beat=%0d stall=%0d want 0/0/0",
               occupancy, beat_cnt, stall_cnt); end
    sys_rst_n = 1'b1;
    #1;
    tests++; if (ready_up !== 1'b1) begin fails++;
      $display("FAIL reset_ready_up: got %b want 1", ready_up); end
  endtask

  // Push 3,5,7 with ready_down=1; outputs appear two edges after the first accept.
  task automatic test_latency();
    logic              pv [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [DATA_W-1:0] pd [5] = '{3'd3, 3'd5, 3'd7, 3'd0, 3'd0};
    logic              ev [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [DATA_W-1:0] ed [5] = '{3'd0, 3'd3, 3'd5, 3'd7, 3'd0};
    ready_down = 1'b1;
    for (int i = 0; i < 5; i++) begin
      valid_up = pv[i]; data_up = pd[i];
      #1;
      tests++; if (ready_up !== 1'b1) begin fails++;
        $display("FAIL latency_ready_up[%0d]: got %b want 1", i, ready_up); end
      tick();
      tests++; if (valid_down !== ev[i]) begin fails++;
        $display("FAIL latency_valid[%0d]: got %b want %b", i, valid_down, ev[i]); end
      if (ev[i]) begin
        tests++; if (data_down !== ed[i]) begin fails++;
          $display("FAIL latency_data[%0d]: got %0d want %0d", i, data_down, ed[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    ready_down = 1'b0; valid_up = 1'b1; data_up = 3'd1;
    #1;
    tests++; if (ready_up !== 1'b1) begin fails++;
      $display("FAIL bp_accept1: got %b want 1", ready_up); end
    tick();
    data_up = 3'd2;
    #1;
    tests++; if (ready_up !== 1'b1) begin fails++;
      $display("FAIL bp_accept2: got %b want 1", ready_up); end
    tick();
    data_up = 3'd3;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++; if (ready_up !== 1'b0) begin fails++;
        $display("FAIL bp_full_ready[%0d]: got %b want 0", i, ready_up); end
      tests++; if (valid_down !== 1'b1 || data_down !== 3'd1) begin fails++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%0d want v=1 d=1", i, valid_down, data_down); end
      tick();
    end
    ready_down = 1'b1;
    #1;
    tests++; if (ready_up !== 1'b1) begin fails++;
      $display("FAIL bp_release_ready: got %b want 1", ready_up); end
    tick();
    valid_up = 1'b0;
    tests++; if (valid_down !== 1'b1 || data_down !== 3'd2) begin fails++;
      $display("FAIL bp_out2: got v=%b d=%0d want v=1 d=2", valid_down, data_down); end
    tick();
    tests++; if (valid_down !== 1'b1 || data_down !== 3'd3) begin fails++;
      $display("FAIL bp_out3: got v=%b d=%0d want v=1 d=3", valid_down, data_down); end
    tick();
    tests++; if (valid_down !== 1'b0) begin fails++;
      $display("FAIL bp_empty: got %b want 0", valid_down); end
  endtask

  task automatic test_full_throughput();
    logic [3:0] occ_want;
`ifdef PIPE_STAT_EN
    occ_want = 4'd2;
`else
    occ_want = 4'd0;
`endif
    ready_down = 1'b0; valid_up = 1'b1; data_up = 3'd6;
    tick(); tick();
    tests++; if (ready_up !== 1'b0) begin fails++;
      $display("FAIL thru_full_ready: got %b want 0", ready_up); end
    ready_down = 1'b1;
    #1;
    tests++; if (ready_up !== 1'b1) begin fails++;
      $display("FAIL thru_passthru_ready: got %b want 1", ready_up); end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if (valid_down !== 1'b1 || data_down !== 3'd6 || ready_up !== 1'b1) begin
        fails++;
        $display("FAIL thru_stream[%0d]: got v=%b d=%0d r=%b want v=1 d=6 r=1",
                 i, valid_down, data_down, ready_up); end
      tests++; if (occupancy !== occ_want) begin fails++;
        $display("FAIL thru_occ[%0d]: got %0d want %0d", i, occupancy, occ_want); end
    end
    valid_up = 1'b0;
    tick(); tick();
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] sb [$];
    logic              stall_prev = 1'b0;
    logic [DATA_W-1:0] prev_dat = '0;
    logic [DATA_W-1:0] want;
    for (int i = 0; i < 1000; i++) begin
      valid_up   = 1'($urandom_range(0, 1));
      data_up    = DATA_W'($urandom);
      ready_down = (i % 2 == 0);
      #1;
      if (stall_prev) begin
        tests++; if (valid_down !== 1'b1 || data_down !== prev_dat) begin fails++;
          $display("FAIL rand_stable[%0d]: got v=%b d=%0d want v=1 d=%0d",
                   i, valid_down, data_down, prev_dat); end
      end
      tests++; if (ready_up !== ((sb.size() < STAGES) || ready_down)) begin fails++;
        $display("FAIL rand_ready[%0d]: got %b with %0d held, ready_down=%b",
                 i, ready_up, sb.size(), ready_down); end
`ifdef PIPE_STAT_EN
      tests++; if (int'(occupancy) != sb.size()) begin fails++;
        $display("FAIL rand_occ[%0d]: got %0d want %0d", i, occupancy, sb.size()); end
`endif
      if (valid_down && ready_down) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL rand_extra[%0d]: got beat %0d want none", i, data_down);
        end else begin
          want = sb.pop_front();
          tests++; if (data_down !== want) begin fails++;
            $display("FAIL rand_data[%0d]: got %0d want %0d", i, data_down, want); end
        end
      end
      if (valid_up && ready_up) sb.push_back(data_up);
      stall_prev = valid_down && !ready_down;
      prev_dat   = data_down;
      tick();
    end
    valid_up = 1'b0; ready_down = 1'b1;
    for (int i = 0; i < 2 * STAGES + 2; i++) begin
      #1;
      if (valid_down && sb.size() != 0) begin
        want = sb.pop_front();
        tests++; if (data_down !== want) begin fails++;
          $display("FAIL rand_drain[%0d]: got %0d want %0d", i, data_down, want); end
      end
      tick();
    end
    tests++; if (sb.size() != 0 || valid_down !== 1'b0) begin fails++;
      $display("FAIL rand_lost: got %0d undelivered, v=%b want 0, v=0", sb.size(), valid_down); end
  endtask

  task automatic test_reset_mid();
    ready_down = 1'b0; valid_up = 1'b1; data_up = 3'd1;
    tick();
    data_up = 3'd2;
    tick();
    valid_up = 1'b0;
    #2;
    sys_rst_n = 1'b0;
    #1;
    tests++; if (valid_down !== 1'b0 || data_down !== 3'd0 || ready_up !== 1'b1) begin fails++;
      $display("FAIL rstmid_async: got v=%b d=%0d r=%b want v=0 d=0 r=1",
               valid_down, data_down, ready_up); end
    tick(); tick();
    sys_rst_n = 1'b1; ready_down = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (valid_down !== 1'b0 || ready_up !== 1'b1) begin fails++;
        $display("FAIL rstmid_stale[%0d]: got v=%b r=%b want v=0 r=1", i, valid_down, ready_up); end
      tick();
    end
  endtask

  // Two beats stall for 4 cycles, then 8 more stream through: 10 beats, 4 stalls.
  task automatic test_stats();
    logic [3:0]       occ_want;
    logic [CNT_W-1:0] beat_want, stall_want;
    int               delivered = 0;
`ifdef PIPE_STAT_EN
    occ_want = 4'd2; beat_want = 16'd10; stall_want = 16'd4;
`else
    occ_want = 4'd0; beat_want = 16'd0; stall_want = 16'd0;
`endif
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      ready_down = (c >= 6);
      valid_up   = (c < 2) || (c >= 6 && c < 14);
      data_up    = DATA_W'(c);
      #1;
      if (c == 2) begin
        tests++; if (occupancy !== occ_want) begin fails++;
          $display("FAIL stats_occ: got %0d want %0d", occupancy, occ_want); end
      end
      if (valid_down && ready_down) delivered++;
      tick();
    end
    tests++; if (delivered != 10) begin fails++;
      $display("FAIL stats_delivered: got %0d want 10", delivered); end
    tests++; if (beat_cnt !== beat_want) begin fails++;
      $display("FAIL stats_beat_cnt: got %0d want %0d", beat_cnt, beat_want); end
    tests++; if (stall_cnt !== stall_want) begin fails++;
      $display("FAIL stats_stall_cnt: got %0d want %0d", stall_cnt, stall_want); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_full_throughput();
    test_random();
    test_reset_mid();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_valid_beat.md
Name: pipe_valid_beat

Overview:
Forward-registered valid/data pipeline for the team's valid/ready handshake. It is the counterpart of the ready-beat pipe: that block registers the backward (ready) path, and this one registers the forward (valid, data) path through STAGES register slices. Each stage collapses bubbles, so full throughput is kept. It sits between a producer and a consumer to break long valid/data timing paths.

Parameters:
DATA_W, 3, payload width in bits
STAGES, 2, number of forward register slices (1 to 8)
CNT_W, 16, width of the statistics counters (used only with PIPE_STAT_EN)

Ports:
sys_clk  input  1  clock; all state updates on the rising edge
sys_rst_n  input  1  asynchronous, active-low reset
valid_up  input  1  producer has a beat
data_up  input  DATA_W  producer payload
ready_up  output  1  block accepts the beat this cycle
valid_down  output  1  registered valid from the last stage
data_down  output  DATA_W  registered payload from the last stage
ready_down  input  1  consumer accepts the beat
occupancy  output  4  number of valid stages (PIPE_STAT_EN only, else 0)
beat_cnt  output  CNT_W  beats delivered downstream (PIPE_STAT_EN only, else 0)
stall_cnt  output  CNT_W  cycles with valid_down=1 and ready_down=0 (PIPE_STAT_EN only, else 0)

Behaviour:
- Reset: one clock; sys_rst_n is asynchronous and active-low. While sys_rst_n=0, all stage valids, stage data and counters are 0. Therefore valid_down=0, data_down=0, occupancy=0 and beat_cnt=stall_cnt=0.
- Stage k holds vld[k] and dat[k]. Stage 0 is fed by the up port; stage STAGES-1 drives the down port.
- rdy[k] = !vld[k] || rdy[k+1], with rdy[STAGES] = ready_down.
  - This ready is combinational; the ready path is intentionally not registered here. Chain it with the ready-beat pipe to register both paths.
- ready_up = rdy[0]. ready_up is 1 out of reset.
- At a clock edge, if rdy[k]=1: vld[k] <= in_valid and dat[k] <= in_data.
  - in_valid/in_data is valid_up/data_up for k=0, else vld[k-1]/dat[k-1].
  - If rdy[k]=0, the stage holds.
- Data is loaded only when in_valid=1. An empty stage keeps its stale data, but valid=0 masks it.
- Transfer happens when valid and ready are both 1 in the same cycle, on both ports.
- Latency: a beat accepted at edge N appears on valid_down after edge N+STAGES-1, i.e. STAGES cycles from acceptance, when not stalled.
- Throughput: 1 beat/cycle when ready_down=1 continuously.
- Bubble collapse: with ready_down=0, upstream stages keep filling until all STAGES hold valid beats. Then ready_up=0.
- Capacity is exactly STAGES beats. No beat is dropped or duplicated. Order is preserved.
- Stability: while valid_down=1 and ready_down=0, valid_down and data_down hold stable.
- Simultaneous events: when full and ready_down=1, ready_up=1 in the same cycle (pass-through shift). Simultaneous push and pop keeps occupancy unchanged.
- valid_up=0 with ready_up=1 shifts a bubble into stage 0.
- Reset mid-operation: all in-flight beats are discarded immediately. There is no residual valid after sys_rst_n is released.

Optional Feature:
PIPE_STAT_EN
- Defined:
  - occupancy = popcount(vld).
  - beat_cnt increments when valid_down && ready_down.
  - stall_cnt increments when valid_down && !ready_down.
  - Both counters wrap modulo 2^CNT_W.
- Undefined: the three outputs are tied to 0 and no counter flops are synthesized. Handshake behaviour is identical either way.

Decomposition:
- pipe_pkg: holds the default DATA_W and STAGES constants, STAGES_MAX=8, and the occupancy width constant OCC_W=4. It is shared with the ready-beat pipe.
- Sub-module pipe_valid_stage: one slice with valid/data registers and the rdy equation.
- pipe_valid_beat: instantiates STAGES pipe_valid_stage slices in a generate loop, plus the optional stats logic.

Test Plan:
1. Reset, then ready_down=1 and STAGES=2; push 3,5,7 on consecutive cycles -> valid_down high 2 cycles after the first accept; data_down 3,5,7 on consecutive cycles; ready_up stays 1.
2. ready_down=0 with a continuous push of 1,2,3 -> ready_up=1 for 2 accepts (1,2), then 0 with 3 held on data_up. Release ready_down -> output 1,2,3 in order, no loss.
3. Full pipe, ready_down=1, valid_up=1 with data 6 every cycle -> one accept and one delivery per cycle, occupancy stays 2.
4. Alternate ready_down 1/0 with random valid_up, 1000 cycles -> scoreboard sequence matches; data_down is stable during every stall.
5. Assert sys_rst_n=0 asynchronously mid-transfer with 2 beats in flight -> valid_down=0 immediately; after release, ready_up=1 and no stale beat appears.
6. PIPE_STAT_EN defined, 10 delivered beats and 4 stall cycles -> beat_cnt=10, stall_cnt=4. Undefined -> all three stats outputs read 0.
